// File: rtl/axis_broadcaster_buffered.sv
// axis_broadcaster_buffered: N-way AXI4-Stream fan-out with a small FIFO per output and a packet-latched enable mask.
// Define AXIS_BCAST_STATS_EN to add the STALL_COUNT/PKT_COUNT statistics outputs.
module axis_broadcaster_buffered #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_OUTPUTS = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              AXIS_ACLK,
    input  logic                              AXIS_ARESETN,
    input  logic [NUM_OUTPUTS-1:0]            OUT_ENABLE,
    input  logic [DATA_WIDTH-1:0]             S_AXIS_TDATA,
    input  logic                              S_AXIS_TVALID,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [NUM_OUTPUTS-1:0]            M_AXIS_TVALID,
    output logic [NUM_OUTPUTS-1:0]            M_AXIS_TLAST,
    input  logic [NUM_OUTPUTS-1:0]            M_AXIS_TREADY
`ifdef AXIS_BCAST_STATS_EN
    ,
    output logic [31:0]                       STALL_COUNT,
    output logic [31:0]                       PKT_COUNT
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                 state_q;
    logic [NUM_OUTPUTS-1:0] active_mask_q, eff_mask, full, push;
    logic                   accept;

    // Ready depends only on FIFO occupancy, never on the sinks' TREADY.
    always_comb begin
        eff_mask      = (state_q == IDLE) ? OUT_ENABLE : active_mask_q;
        S_AXIS_TREADY = AXIS_ARESETN & (&(~eff_mask | ~full));
        accept        = S_AXIS_TVALID & S_AXIS_TREADY;
        push          = accept ? eff_mask : '0;
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            state_q       <= IDLE;
            active_mask_q <= '0;
        end else if (accept) begin
            if (state_q == IDLE) active_mask_q <= OUT_ENABLE;
            state_q <= S_AXIS_TLAST ? IDLE : IN_PKT;
        end
    end

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
        logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0]       wr_q, rd_q;
        logic [CW-1:0]       cnt_q, cnt_d;
        logic                pop;

        assign full[i]          = cnt_q == CW'(FIFO_DEPTH);
        assign M_AXIS_TVALID[i] = cnt_q != '0;
        assign pop              = M_AXIS_TVALID[i] & M_AXIS_TREADY[i];
        assign cnt_d            = cnt_q + CW'(push[i]) - CW'(pop);
        assign {M_AXIS_TLAST[i], M_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH]} =
            M_AXIS_TVALID[i] ? mem_q[rd_q] : '0;

        always_ff @(posedge AXIS_ACLK) begin
            if (push[i]) mem_q[wr_q] <= {S_AXIS_TLAST, S_AXIS_TDATA};
        end

        always_ff @(posedge AXIS_ACLK) begin
            if (!AXIS_ARESETN) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_q + AW'(push[i]);
                rd_q  <= rd_q + AW'(pop);
                cnt_q <= cnt_d;
            end
        end
    end

`ifdef AXIS_BCAST_STATS_EN
    logic [31:0] stall_q, pkt_q;

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            stall_q <= '0;
            pkt_q   <= '0;
        end else begin
            if (S_AXIS_TVALID & ~S_AXIS_TREADY & (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (accept & S_AXIS_TLAST & (pkt_q != '1)) pkt_q <= pkt_q + 32'd1;
        end
    end

    assign STALL_COUNT = stall_q;
    assign PKT_COUNT   = pkt_q;
`endif
endmodule

// File: tb/tb_axis_broadcaster_buffered.sv
// tb_axis_broadcaster_buffered: directed stimulus with per-output scoreboard queues and an independent monitor.
module tb_axis_broadcaster_buffered;
    logic        clk, rstn;
    logic [2:0]  en;
    logic [31:0] s_data;
    logic        s_valid, s_last, s_ready;
    logic [95:0] m_data;
    logic [2:0]  m_valid, m_last, m_ready;
`ifdef AXIS_BCAST_STATS_EN
    logic [31:0] stall_cnt, pkt_cnt;
`endif

    axis_broadcaster_buffered #(.DATA_WIDTH(32), .NUM_OUTPUTS(3), .FIFO_DEPTH(4)) dut (
        .AXIS_ACLK(clk),
        .AXIS_ARESETN(rstn),
        .OUT_ENABLE(en),
        .S_AXIS_TDATA(s_data),
        .S_AXIS_TVALID(s_valid),
        .S_AXIS_TLAST(s_last),
        .S_AXIS_TREADY(s_ready),
        .M_AXIS_TDATA(m_data),
        .M_AXIS_TVALID(m_valid),
        .M_AXIS_TLAST(m_last),
        .M_AXIS_TREADY(m_ready)
`ifdef AXIS_BCAST_STATS_EN
        ,
        .STALL_COUNT(stall_cnt),
        .PKT_COUNT(pkt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [32:0] exp_q [3][$];
    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Holds TVALID until accepted; expected beats go to the queues of mask m.
    task automatic send(input logic [31:0] d, input logic l, input logic [2:0] m, output int st);
        logic acc;
        acc = 1'b0;
        st = 0;
        s_data = d;
        s_last = l;
        s_valid = 1'b1;
        while (!acc && st < 100) begin
            @(negedge clk);
            if (s_ready) begin
                acc = 1'b1;
                for (int i = 0; i < 3; i++) if (m[i]) exp_q[i].push_back({l, d});
            end else st++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk($sformatf("accept %0h", d), 64'(acc), 64'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'(0));
    endtask

    initial begin
        int st, sum;
        logic [32:0] e;
        fork
            forever begin
                @(negedge clk);
                if (rstn) begin
                    for (int i = 0; i < 3; i++) begin
                        if (m_valid[i] && m_ready[i]) begin
                            if (exp_q[i].size() == 0) begin
                                total++;
                                $display("FAIL out%0d unexpected: got %0h expected none", i, {m_last[i], m_data[i*32 +: 32]});
                            end else begin
                                e = exp_q[i].pop_front();
                                chk($sformatf("out%0d beat", i), 64'({m_last[i], m_data[i*32 +: 32]}), 64'(e));
                            end
                        end
                    end
                end
            end
        join_none

        // Reset held with TVALID asserted
        rstn = 1'b0; en = 3'b111; m_ready = 3'b111;
        s_valid = 1'b1; s_data = 32'hDEAD; s_last = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst tready", 64'(s_ready), 64'(0));
            chk("rst tvalid", 64'(m_valid), 64'(0));
            chk("rst tdata", 64'(m_data != 96'd0), 64'(0));
        end
        rstn = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;

        // Full broadcast, one-cycle latency, no stall
        sum = 0;
        for (int k = 1; k <= 8; k++) begin
            send(32'(k), k == 8, 3'b111, st);
            sum += st;
            if (k == 1) chk("latency", 64'(m_valid), 64'(3'b111));
        end
        chk("no stall", 64'(sum), 64'(0));
        drain();

        // Output 1 stalled: its FIFO fills, then drains in order
        m_ready = 3'b101;
        sum = 0;
        for (int k = 1; k <= 4; k++) begin
            send(32'h10 + 32'(k), 1'b0, 3'b111, st);
            sum += st;
        end
        chk("fill no stall", 64'(sum), 64'(0));
        s_data = 32'h15; s_last = 1'b1; s_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("full tready", 64'(s_ready), 64'(0));
            if (k == 0) chk("hold out1", 64'({m_last[1], m_data[63:32]}), 64'(33'h0_0000_0011));
            @(posedge clk);
            #1;
        end
        m_ready = 3'b111;
        send(32'h15, 1'b1, 3'b111, st);
        chk("one pop stall", 64'(st), 64'(1));
        drain();
`ifdef AXIS_BCAST_STATS_EN
        chk("pkt count", 64'(pkt_cnt), 64'(2));
        chk("stall count", 64'(stall_cnt), 64'(7));
`endif

        // Enable change mid-packet only applies to the next packet
        en = 3'b111;
        send(32'h21, 1'b0, 3'b111, st);
        send(32'h22, 1'b0, 3'b111, st);
        en = 3'b101;
        for (int k = 3; k <= 6; k++) send(32'h20 + 32'(k), k == 6, 3'b111, st);
        send(32'h31, 1'b0, 3'b101, st);
        send(32'h32, 1'b1, 3'b101, st);
        drain();

        // All outputs disabled: beats are dropped without stalling
        en = 3'b000;
        for (int k = 1; k <= 5; k++) begin
            send(32'h40 + 32'(k), k == 5, 3'b000, st);
            chk("drop no stall", 64'(st), 64'(0));
            chk("drop no valid", 64'(m_valid), 64'(0));
        end
        en = 3'b001;
        send(32'h51, 1'b0, 3'b001, st);
        send(32'h52, 1'b1, 3'b001, st);
        drain();

        // Reset mid-packet discards buffered beats and returns to IDLE
        en = 3'b111; m_ready = 3'b000;
        send(32'h61, 1'b0, 3'b000, st);
        send(32'h62, 1'b0, 3'b000, st);
        chk("pre-rst valid", 64'(m_valid), 64'(3'b111));
        rstn = 1'b0; en = 3'b010;
        @(posedge clk);
        #1;
        chk("mid rst valid", 64'(m_valid), 64'(0));
        chk("mid rst tready", 64'(s_ready), 64'(0));
`ifdef AXIS_BCAST_STATS_EN
        chk("rst pkt count", 64'(pkt_cnt), 64'(0));
        chk("rst stall count", 64'(stall_cnt), 64'(0));
`endif
        rstn = 1'b1; m_ready = 3'b111;
        send(32'h71, 1'b1, 3'b010, st);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("idle end", 64'(m_valid), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
